// File: rtl/cc_muxn_reg.sv
// rtl/cc_muxn_reg.sv - registered N:1 priority bus mux with zero guard cycles on channel change
module cc_muxn_reg #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  parameter int BLANK = 1,
  parameter int HOLD_MODE = 0,
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 CC_MUXN_CLOCK_50,
  input  logic                 CC_MUXN_RESET_InLow,
  input  logic [NCH-1:0]       CC_MUXN_select_InLow,
  input  logic [NCH*WIDTH-1:0] CC_MUXN_data_InBUS,
  output logic [WIDTH-1:0]     CC_MUXN_z_Out_Bus,
  output logic                 CC_MUXN_valid_Out,
  output logic [CW-1:0]        CC_MUXN_chan_Out
);

  // Guard counter only has to hold BLANK-1.
  localparam int BW = (BLANK > 1) ? $clog2(BLANK) : 1;

  typedef enum logic [1:0] {
    stIdle,
    stPass,
    stBlank
  } state_t;

  state_t           stateQ, stateD;
  logic [WIDTH-1:0] zQ, zD;
  logic             validQ, validD;
  logic [CW-1:0]    chanQ, chanD;
  logic [BW-1:0]    cntQ, cntD;

  logic [NCH-1:0]   req;
  logic             anyReq;
  logic [CW-1:0]    win;
  logic [WIDTH-1:0] winData;
  logic [WIDTH-1:0] idleZ;

  assign req    = ~CC_MUXN_select_InLow;
  assign anyReq = |req;

  // Value z takes when nobody is selected: cleared, or kept in hold mode.
  assign idleZ = (HOLD_MODE != 0) ? zQ : '0;

  // Priority pick: scanning downward leaves the lowest requesting index.
  always_comb begin
    win     = '0;
    winData = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        win     = CW'(i);
        winData = CC_MUXN_data_InBUS[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-output decode; valid is only raised while passing data.
  always_comb begin
    stateD = stateQ;
    zD     = zQ;
    validD = 1'b0;
    chanD  = chanQ;
    cntD   = cntQ;
    case (stateQ)
      stIdle: begin
        if (anyReq) begin
          // No previous driver, so no guard is needed.
          stateD = stPass;
          zD     = winData;
          chanD  = win;
          validD = 1'b1;
        end else begin
          zD = idleZ;
        end
      end
      stPass: begin
        if (!anyReq) begin
          stateD = stIdle;
          zD     = idleZ;
        end else if (win == chanQ) begin
          zD     = winData;
          validD = 1'b1;
        end else if (BLANK == 0) begin
          zD     = winData;
          chanD  = win;
          validD = 1'b1;
        end else begin
          // This edge emits the first zero; the counter covers the rest.
          stateD = stBlank;
          zD     = '0;
          chanD  = win;
          cntD   = BW'(BLANK - 1);
        end
      end
      stBlank: begin
        zD = '0;
        if (cntQ != '0) begin
          cntD = cntQ - BW'(1);
        end else if (anyReq) begin
          // Guard finished: re-sample the requests afresh.
          stateD = stPass;
          zD     = winData;
          chanD  = win;
          validD = 1'b1;
        end else begin
          stateD = stIdle;
        end
      end
      default: begin
        stateD = stIdle;
        zD     = '0;
      end
    endcase
  end

  // State and output registers; reset clears everything without waiting for a clock.
  always_ff @(posedge CC_MUXN_CLOCK_50 or negedge CC_MUXN_RESET_InLow) begin
    if (!CC_MUXN_RESET_InLow) begin
      stateQ <= stIdle;
      zQ     <= '0;
      validQ <= 1'b0;
      chanQ  <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      zQ     <= zD;
      validQ <= validD;
      chanQ  <= chanD;
      cntQ   <= cntD;
    end
  end

  assign CC_MUXN_z_Out_Bus = zQ;
  assign CC_MUXN_valid_Out = validQ;
  assign CC_MUXN_chan_Out  = chanQ;

endmodule

// File: tb/tb_cc_muxn_reg.sv
// tb/tb_cc_muxn_reg.sv - directed and randomized checks of cc_muxn_reg against a reference model
`timescale 1ns/1ps
module tb_cc_muxn_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;
  int nDone   = 0;

  // Random regression configurations, cfg0 in the least significant byte.
  localparam int NCFG = 7;
  localparam logic [NCFG*8-1:0] CFG_N = {8'd4, 8'd1, 8'd3, 8'd4, 8'd4, 8'd3, 8'd1};
  localparam logic [NCFG*8-1:0] CFG_W = {8'd1, 8'd8, 8'd12, 8'd8, 8'd12, 8'd8, 8'd1};
  localparam logic [NCFG*8-1:0] CFG_B = {8'd1, 8'd3, 8'd3, 8'd0, 8'd3, 8'd1, 8'd0};
  localparam logic [NCFG*8-1:0] CFG_H = {8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd0};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Directed instance A: guard of 2, zero when idle.
  logic       aRstN;
  logic [3:0] aSel;
  logic [31:0] aData;
  logic [7:0] aZ;
  logic       aValid;
  logic [1:0] aChan;

  cc_muxn_reg #(.WIDTH(8), .NCH(4), .BLANK(2), .HOLD_MODE(0)) dutA (
    .CC_MUXN_CLOCK_50    (clk),
    .CC_MUXN_RESET_InLow (aRstN),
    .CC_MUXN_select_InLow(aSel),
    .CC_MUXN_data_InBUS  (aData),
    .CC_MUXN_z_Out_Bus   (aZ),
    .CC_MUXN_valid_Out   (aValid),
    .CC_MUXN_chan_Out    (aChan)
  );

  // Directed instance B: immediate switch, hold when idle.
  logic       bRstN;
  logic [3:0] bSel;
  logic [31:0] bData;
  logic [7:0] bZ;
  logic       bValid;
  logic [1:0] bChan;

  cc_muxn_reg #(.WIDTH(8), .NCH(4), .BLANK(0), .HOLD_MODE(1)) dutB (
    .CC_MUXN_CLOCK_50    (clk),
    .CC_MUXN_RESET_InLow (bRstN),
    .CC_MUXN_select_InLow(bSel),
    .CC_MUXN_data_InBUS  (bData),
    .CC_MUXN_z_Out_Bus   (bZ),
    .CC_MUXN_valid_Out   (bValid),
    .CC_MUXN_chan_Out    (bChan)
  );

  task automatic expA(input string tag, input logic [7:0] z, input logic v, input logic [1:0] c);
    checkVal({tag, ".z"}, 32'(aZ), 32'(z));
    checkVal({tag, ".valid"}, 32'(aValid), 32'(v));
    checkVal({tag, ".chan"}, 32'(aChan), 32'(c));
  endtask

  task automatic expB(input string tag, input logic [7:0] z, input logic v, input logic [1:0] c);
    checkVal({tag, ".z"}, 32'(bZ), 32'(z));
    checkVal({tag, ".valid"}, 32'(bValid), 32'(v));
    checkVal({tag, ".chan"}, 32'(bChan), 32'(c));
  endtask

  initial begin : directed
    aRstN = 1'b0; aSel = 4'($urandom); aData = $urandom;
    bRstN = 1'b0; bSel = 4'($urandom); bData = $urandom;
    tick;
    aSel = 4'($urandom); aData = $urandom;
    bSel = 4'($urandom); bData = $urandom;
    tick;
    expA("rstA", 8'h00, 1'b0, 2'd0);
    expB("rstB", 8'h00, 1'b0, 2'd0);
    #3;
    aRstN = 1'b1; bRstN = 1'b1;

    aSel = 4'b1110; aData = $urandom; aData[7:0] = 8'hA5;
    tick; expA("passA5", 8'hA5, 1'b1, 2'd0);
    aData[7:0] = 8'h3C;
    tick; expA("pass3C", 8'h3C, 1'b1, 2'd0);

    aSel = 4'b1010; aData[7:0] = 8'h11; aData[23:16] = 8'h22;
    tick; expA("prio", 8'h11, 1'b1, 2'd0);
    aData[23:16] = 8'h55;
    tick; expA("prioMask", 8'h11, 1'b1, 2'd0);

    aData[23:16] = 8'h22; aSel = 4'b1011;
    tick; expA("guard1", 8'h00, 1'b0, 2'd2);
    aSel = 4'b0111;
    tick; expA("guard2", 8'h00, 1'b0, 2'd2);
    aSel = 4'b1011;
    tick; expA("afterGuard", 8'h22, 1'b1, 2'd2);

    aSel = 4'b1111;
    tick; expA("releaseZero", 8'h00, 1'b0, 2'd2);
    aSel = 4'b1101; aData[15:8] = 8'h9A;
    tick; expA("reselect", 8'h9A, 1'b1, 2'd1);

    #2; aRstN = 1'b0;
    #1; expA("asyncPass", 8'h00, 1'b0, 2'd0);
    #1; aRstN = 1'b1;
    tick; expA("postRst", 8'h9A, 1'b1, 2'd1);
    aSel = 4'b1011;
    tick; expA("guardAgain", 8'h00, 1'b0, 2'd2);
    #2; aRstN = 1'b0;
    #1; expA("asyncGuard", 8'h00, 1'b0, 2'd0);
    aSel = 4'b0111; aData[31:24] = 8'h77;
    #1; aRstN = 1'b1;
    tick; expA("rstRelease", 8'h77, 1'b1, 2'd3);

    bSel = 4'b1110; bData = $urandom; bData[7:0] = 8'h11;
    tick; expB("bPass", 8'h11, 1'b1, 2'd0);
    bSel = 4'b1011; bData[23:16] = 8'h22;
    tick; expB("bSwitch", 8'h22, 1'b1, 2'd2);
    bSel = 4'b1111;
    tick; expB("bHold", 8'h22, 1'b0, 2'd2);
    bData = $urandom;
    tick; expB("bHold2", 8'h22, 1'b0, 2'd2);
    bSel = 4'b1101; bData[15:8] = 8'h44;
    tick; expB("bReselect", 8'h44, 1'b1, 2'd1);

    nDone++;
  end

  for (genvar g = 0; g < NCFG; g++) begin : gRand
    localparam int N = int'(CFG_N[g*8 +: 8]);
    localparam int W = int'(CFG_W[g*8 +: 8]);
    localparam int B = int'(CFG_B[g*8 +: 8]);
    localparam int H = int'(CFG_H[g*8 +: 8]);
    localparam int CWG = (N > 1) ? $clog2(N) : 1;

    logic           rstN;
    logic [N-1:0]   sel;
    logic [N*W-1:0] data;
    logic [W-1:0]   z;
    logic           valid;
    logic [CWG-1:0] chan;

    cc_muxn_reg #(.WIDTH(W), .NCH(N), .BLANK(B), .HOLD_MODE(H)) dut (
      .CC_MUXN_CLOCK_50    (clk),
      .CC_MUXN_RESET_InLow (rstN),
      .CC_MUXN_select_InLow(sel),
      .CC_MUXN_data_InBUS  (data),
      .CC_MUXN_z_Out_Bus   (z),
      .CC_MUXN_valid_Out   (valid),
      .CC_MUXN_chan_Out    (chan)
    );

    initial begin : stim
      // Model: which channel owns the bus, and how many guard zeros remain to emit.
      int mZ;
      int mChan;
      int mGuard;
      bit mValid;
      bit mDriving;
      int win;
      bit anyR;
      logic [N-1:0] req;

      mZ = 0; mChan = 0; mGuard = 0; mValid = 0; mDriving = 0;
      rstN = 1'b0;
      repeat (3) begin
        sel = N'($urandom);
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
        tick;
        checkVal($sformatf("cfg%0d.rst.z", g), 32'(z), 32'(mZ));
        checkVal($sformatf("cfg%0d.rst.valid", g), 32'(valid), 32'(mValid));
        checkVal($sformatf("cfg%0d.rst.chan", g), 32'(chan), 32'(mChan));
      end
      #2 rstN = 1'b1;

      for (int cyc = 0; cyc < 10000; cyc++) begin
        if ($urandom_range(3) == 0) sel = N'($urandom);
        for (int i = 0; i < N; i++) data[i*W +: W] = W'($urandom);
        tick;

        req  = ~sel;
        anyR = |req;
        win  = 0;
        for (int i = N - 1; i >= 0; i--) if (req[i]) win = i;

        if (mGuard > 0) begin
          mGuard--;
          mZ = 0;
          mValid = 0;
        end else if (!anyR) begin
          mValid = 0;
          mDriving = 0;
          if (H == 0) mZ = 0;
        end else if (!mDriving || win == mChan || B == 0) begin
          mZ = int'(data[win*W +: W]);
          mChan = win;
          mValid = 1;
          mDriving = 1;
        end else begin
          mZ = 0;
          mValid = 0;
          mChan = win;
          mDriving = 0;
          mGuard = B - 1;
        end

        checkVal($sformatf("cfg%0d.z", g), 32'(z), 32'(mZ));
        checkVal($sformatf("cfg%0d.valid", g), 32'(valid), 32'(mValid));
        checkVal($sformatf("cfg%0d.chan", g), 32'(chan), 32'(mChan));

        if ($urandom_range(499) == 0) begin
          #2 rstN = 1'b0;
          #1;
          mZ = 0; mChan = 0; mGuard = 0; mValid = 0; mDriving = 0;
          checkVal($sformatf("cfg%0d.async.z", g), 32'(z), 32'(mZ));
          checkVal($sformatf("cfg%0d.async.valid", g), 32'(valid), 32'(mValid));
          checkVal($sformatf("cfg%0d.async.chan", g), 32'(chan), 32'(mChan));
          #1 rstN = 1'b1;
        end
      end
      nDone++;
    end
  end

  initial begin : finish
    int waitCyc;
    waitCyc = 0;
    while (nDone < NCFG + 1 && waitCyc < 20000) begin
      @(posedge clk);
      waitCyc++;
    end
    checkVal("allDone", 32'(nDone), 32'(NCFG + 1));
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/cc_muxn_reg.md
Name: cc_muxn_reg

Overview:
Parametrised, registered N:1 bus multiplexer with per-channel active-low selects and fixed priority (lowest index wins). It drives a shared pixel/data bus (e.g. sprite or score layers onto the video data path). It inserts a programmable number of zero "guard" cycles whenever the driving channel changes, so two sources never appear back-to-back on the bus. When no channel is selected, the bus outputs zero or holds its last value, depending on mode.

Parameters:
WIDTH, 8, bits per channel and output bus width
NCH, 4, number of input channels (>=1)
BLANK, 1, zero guard cycles inserted on a channel change (0 = switch immediately)
HOLD_MODE, 0, 0: output zero when no channel is selected; 1: hold last output value
CW (derived), max(1, clog2(NCH)), channel index width

Ports:
CC_MUXN_CLOCK_50  in  1  system clock, rising edge
CC_MUXN_RESET_InLow  in  1  asynchronous active-low reset
CC_MUXN_select_InLow  in  NCH  per-channel select, bit i low requests channel i
CC_MUXN_data_InBUS  in  NCH*WIDTH  packed data, channel i = bits [i*WIDTH +: WIDTH]
CC_MUXN_z_Out_Bus  out  WIDTH  registered muxed output
CC_MUXN_valid_Out  out  1  high when z carries a channel's data (PASS state)
CC_MUXN_chan_Out  out  CW  index of the channel currently driving or next to drive z

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; all state is cleared immediately when reset asserts. Reset values: z=0, valid=0, chan=0, state=IDLE, blank counter=0.
- Combinational decode:
  - req = ~select.
  - any = |req.
  - win = lowest index i with req[i]=1.
- All outputs are registered. Latency from a select/data change to z is 1 clock.
- State machine: IDLE, PASS, BLANK.
- IDLE:
  - any=0 -> stay in IDLE. valid=0. z=0 if HOLD_MODE=0, otherwise z holds its value (0 directly after reset).
  - any=1 -> go to PASS. z<=data[win], chan<=win, valid<=1. No guard cycles, because no previous driver exists.
- PASS:
  - any=0 -> go to IDLE. valid<=0. z<=0 (HOLD_MODE=0) or hold (HOLD_MODE=1). chan holds.
  - win==chan -> z<=data[chan] every cycle, so data changes propagate with 1-cycle latency.
  - win!=chan and BLANK=0 -> stay in PASS. z<=data[win], chan<=win.
  - win!=chan and BLANK>0 -> go to BLANK. z<=0, valid<=0, chan<=win, counter<=BLANK-1.
- BLANK:
  - z is forced to 0 regardless of HOLD_MODE. valid=0.
  - counter!=0 -> counter decrements.
  - counter==0 -> re-sample. any=1 -> PASS with z<=data[win], chan<=win, valid<=1. any=0 -> IDLE.
  - Select changes during BLANK neither restart nor extend the guard. Exactly BLANK zero cycles appear on z.
- A higher-priority request that appears while a lower channel is in PASS counts as a channel change and gets a guard.
- NCH=1: win is always 0, so BLANK is never entered.
- Reset asserted mid-BLANK or mid-PASS returns to reset values immediately. After release, the first edge behaves as IDLE.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and pass-through: WIDTH=8, NCH=4, BLANK=1. Hold reset low with random inputs -> z=0, valid=0, chan=0. Release, then set select=4'b1110 with ch0 data=8'hA5 -> one edge later z=A5, valid=1, chan=0. Change ch0 to 8'h3C -> z=3C on the next edge.
- Priority: select=4'b1010 (ch0 and ch2 requested), data ch0=11, ch2=22 -> z=11, chan=0. Ch2 data changes have no effect on z.
- Guard insertion, BLANK=2: in PASS on ch0 (z=11), switch select to 4'b1011 (ch2, data 22) -> z=0,0 for exactly 2 cycles with valid=0 and chan=2, then z=22, valid=1. Toggle selects during the guard -> still exactly 2 zero cycles. Rerun with BLANK=0 -> z goes 11 then 22 directly.
- Release all selects: in PASS with z=22, set select=4'b1111. HOLD_MODE=0 -> z=0, valid=0. HOLD_MODE=1 -> z stays 22, valid=0. Re-select ch1 -> z=data[1] one cycle later with no guard.
- Async reset mid-guard: assert reset between clock edges during BLANK -> outputs clear immediately, without waiting for a clock edge. Release with select=4'b0111 (ch3, data 8'h77) -> z=77, chan=3 after one edge.
- Random regression: NCH in {1,3,4}, WIDTH in {1,8,12}, BLANK in {0,1,3}. A cycle-accurate reference model matches z, valid and chan on every cycle over 10k cycles.
